// File: rtl/branch_target_buffer_if.sv
// Fetch lookup and execute update signals for the branch target buffer.
// master = pipeline side, slave = branch_target_buffer.
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 2
);
  logic [ADDR_W-1:0] raddr;
  logic              hit;
  logic              pc_source;
  logic [ADDR_W-1:0] predict;
  logic [CNT_W-1:0]  cb;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] wtarget;
  logic              outcome;
  logic [CNT_W-1:0]  wcb;
  logic              invalidate_all;

  modport master (
    output raddr, we, waddr, wtarget, outcome, wcb, invalidate_all,
    input  hit, pc_source, predict, cb
  );

  modport slave (
    input  raddr, we, waddr, wtarget, outcome, wcb, invalidate_all,
    output hit, pc_source, predict, cb
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with saturating direction counters; allocates on taken branches only.
// Optional BTB_WRITE_BYPASS_EN: same-index lookup sees the entry's post-update contents.
module branch_target_buffer #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input logic clk,
  input logic rst_n,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CNT_W-1:0]  cnt_q   [ENTRIES];

  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [TAG_W-1:0]  w_tag, r_tag;
  logic              w_hit;
  logic [CNT_W-1:0]  cnt_next;
  logic              upd_en;
  logic              upd_valid;
  logic [TAG_W-1:0]  upd_tag;
  logic [ADDR_W-1:0] upd_tgt;
  logic [CNT_W-1:0]  upd_cnt;

  logic              ent_valid;
  logic [TAG_W-1:0]  ent_tag;
  logic [ADDR_W-1:0] ent_tgt;
  logic [CNT_W-1:0]  ent_cnt;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.raddr[1:0], bus.waddr[1:0]};

  assign w_idx = bus.waddr[IDX_W+1:2];
  assign w_tag = bus.waddr[ADDR_W-1:IDX_W+2];
  assign r_idx = bus.raddr[IDX_W+1:2];
  assign r_tag = bus.raddr[ADDR_W-1:IDX_W+2];
  assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

  // Counter arithmetic is based on the value that travelled with the branch, not the table copy.
  always_comb begin
    cnt_next = bus.wcb;
    if (bus.outcome) begin
      if (bus.wcb != CNT_MAX) cnt_next = bus.wcb + CNT_W'(1);
    end else begin
      if (bus.wcb != '0) cnt_next = bus.wcb - CNT_W'(1);
    end
  end

  always_comb begin
    upd_valid = valid_q[w_idx];
    upd_tag   = tag_q[w_idx];
    upd_tgt   = tgt_q[w_idx];
    upd_cnt   = cnt_q[w_idx];
    if (w_hit) begin
      upd_cnt = cnt_next;
      if (bus.outcome) upd_tgt = bus.wtarget;
    end else if (bus.outcome) begin
      upd_valid = 1'b1;
      upd_tag   = w_tag;
      upd_tgt   = bus.wtarget;
      upd_cnt   = CNT_WEAK;
    end
  end

  assign upd_en = bus.we && (w_hit || bus.outcome);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (bus.invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_en) begin
      valid_q[w_idx] <= upd_valid;
      tag_q[w_idx]   <= upd_tag;
      tgt_q[w_idx]   <= upd_tgt;
      cnt_q[w_idx]   <= upd_cnt;
    end
  end

  always_comb begin
    ent_valid = valid_q[r_idx];
    ent_tag   = tag_q[r_idx];
    ent_tgt   = tgt_q[r_idx];
    ent_cnt   = cnt_q[r_idx];
`ifdef BTB_WRITE_BYPASS_EN
    if (bus.we && !bus.invalidate_all && (r_idx == w_idx)) begin
      ent_valid = upd_valid;
      ent_tag   = upd_tag;
      ent_tgt   = upd_tgt;
      ent_cnt   = upd_cnt;
    end
`endif
  end

  assign bus.hit       = ent_valid && (ent_tag == r_tag);
  assign bus.cb        = bus.hit ? ent_cnt : '0;
  assign bus.pc_source = bus.hit && bus.cb[CNT_W-1];
  assign bus.predict   = bus.pc_source ? ent_tgt : bus.raddr + ADDR_W'(4);

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer; expectations follow BTB_WRITE_BYPASS_EN if defined.
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_bad = 0;

  branch_target_buffer_if #(.ADDR_W(32), .CNT_W(2)) bus ();

  branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic h, input logic pcs,
                      input logic [31:0] pred, input logic [1:0] c);
    bus.raddr = a;
    #1;
    check({tag, ".hit"},  32'(bus.hit),       32'(h));
    check({tag, ".pcs"},  32'(bus.pc_source), 32'(pcs));
    check({tag, ".pred"}, bus.predict,        pred);
    check({tag, ".cb"},   32'(bus.cb),        32'(c));
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic o, input logic [1:0] c);
    bus.we = 1'b1;
    bus.waddr = a;
    bus.wtarget = t;
    bus.outcome = o;
    bus.wcb = c;
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    bus.raddr = 32'h100;
    bus.we = 1'b0;
    bus.waddr = '0;
    bus.wtarget = '0;
    bus.outcome = 1'b0;
    bus.wcb = '0;
    bus.invalidate_all = 1'b0;

    repeat (2) tick();
    look("in_rst", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
    rst_n = 1'b1;
    tick();
    look("rst", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 2'd0);

    upd(32'h100, 32'h200, 1'b1, 2'd0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200, 2'd2);

    upd(32'h100, 32'h0, 1'b0, 2'd2);
    look("dec1", 32'h100, 1'b1, 1'b0, 32'h104, 2'd1);
    upd(32'h100, 32'h0, 1'b0, 2'd1);
    look("dec0", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);

    upd(32'h100, 32'h220, 1'b1, 2'd3);
    look("sat3", 32'h100, 1'b1, 1'b1, 32'h220, 2'd3);
    upd(32'h100, 32'h999, 1'b0, 2'd3);
    look("nt_keep_tgt", 32'h100, 1'b1, 1'b1, 32'h220, 2'd2);
    upd(32'h100, 32'h999, 1'b0, 2'd0);
    look("sat0", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);

    upd(32'h140, 32'h300, 1'b0, 2'd2);
    look("alias_nt_old", 32'h100, 1'b1, 1'b0, 32'h104, 2'd0);
    look("alias_nt_new", 32'h140, 1'b0, 1'b0, 32'h144, 2'd0);
    upd(32'h140, 32'h300, 1'b1, 2'd0);
    look("alias_t_new", 32'h140, 1'b1, 1'b1, 32'h300, 2'd2);
    look("alias_t_old", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);

    upd(32'h104, 32'h500, 1'b1, 2'd3);
    look("idx1", 32'h104, 1'b1, 1'b1, 32'h500, 2'd2);

    // Same-cycle write/read of one index
    bus.we = 1'b1;
    bus.waddr = 32'h180;
    bus.wtarget = 32'h400;
    bus.outcome = 1'b1;
    bus.wcb = 2'd0;
`ifdef BTB_WRITE_BYPASS_EN
    look("same_cyc", 32'h180, 1'b1, 1'b1, 32'h400, 2'd2);
`else
    look("same_cyc", 32'h180, 1'b0, 1'b0, 32'h184, 2'd0);
`endif
    tick();
    bus.we = 1'b0;
    look("after_wr", 32'h180, 1'b1, 1'b1, 32'h400, 2'd2);

    // Invalidate beats a simultaneous allocate; lookup that cycle sees old state
    bus.invalidate_all = 1'b1;
    bus.we = 1'b1;
    bus.waddr = 32'h1C0;
    bus.wtarget = 32'h600;
    bus.outcome = 1'b1;
    bus.wcb = 2'd0;
    look("inv_cyc", 32'h180, 1'b1, 1'b1, 32'h400, 2'd2);
    tick();
    bus.invalidate_all = 1'b0;
    bus.we = 1'b0;
    look("inv_180", 32'h180, 1'b0, 1'b0, 32'h184, 2'd0);
    look("inv_1c0", 32'h1C0, 1'b0, 1'b0, 32'h1C4, 2'd0);
    look("inv_104", 32'h104, 1'b0, 1'b0, 32'h108, 2'd0);

    // Asynchronous reset mid-operation
    upd(32'h100, 32'h200, 1'b1, 2'd1);
    look("pre_rst", 32'h100, 1'b1, 1'b1, 32'h200, 2'd2);
    rst_n = 1'b0;
    look("async_rst", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);
    #2;
    rst_n = 1'b1;
    tick();
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h104, 2'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
